// File: rtl/ibex_alu_pkg.sv
// ibex_alu_pkg: shared widths, writeback entry type and ALU operator encoding
// for the reduced ALU and its writeback queue.
package ibex_alu_pkg;

    localparam int unsigned XLEN_C = 32;
    localparam int unsigned AW_C   = 5;

    typedef struct packed {
        logic [XLEN_C-1:0] result;
        logic [AW_C-1:0]   rd_addr;
    } wb_entry_t;

    typedef enum logic [6:0] {
        ALU_ADD = 7'h0,
        ALU_SUB = 7'h1,
        ALU_XOR = 7'h2,
        ALU_OR  = 7'h3,
        ALU_AND = 7'h4
    } alu_op_e;

endpackage

// File: rtl/ibex_wb_fwd_lookup.sv
// ibex_wb_fwd_lookup: combinational youngest-match search over the queue
// entries, walking from the head (oldest) so the last match wins.
module ibex_wb_fwd_lookup #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = 5
) (
    input  logic [XLEN-1:0]          result_i [DEPTH],
    input  logic [AW-1:0]            addr_i   [DEPTH],
    input  logic [DEPTH-1:0]         valid_i,
    input  logic [$clog2(DEPTH)-1:0] head_i,
    input  logic [AW-1:0]            lookup_addr_i,
    output logic                     hit_o,
    output logic [XLEN-1:0]          data_o
);

    localparam int unsigned IW = $clog2(DEPTH);

    logic [IW-1:0] idx;

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + IW'(k);
            if (valid_i[idx] && addr_i[idx] == lookup_addr_i && lookup_addr_i != '0) begin
                hit_o  = 1'b1;
                data_o = result_i[idx];
            end
        end
    end

endmodule

// File: rtl/ibex_alu_wb_queue.sv
// ibex_alu_wb_queue: in-order writeback FIFO behind the ALU with forwarding lookup.
// Define IBEX_WB_QUEUE_BYPASS_EN for a zero-latency pass-through when empty.
module ibex_alu_wb_queue
    import ibex_alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = XLEN_C,
    parameter int unsigned AW    = AW_C
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_in_valid,
    output logic                     io_in_ready,
    input  logic [XLEN-1:0]          io_in_result,
    input  logic [AW-1:0]            io_in_rd_addr,
    output logic                     io_out_valid,
    input  logic                     io_out_ready,
    output logic [XLEN-1:0]          io_out_result,
    output logic [AW-1:0]            io_out_rd_addr,
    input  logic                     io_flush,
    input  logic [AW-1:0]            io_lookup_addr,
    output logic                     io_lookup_hit,
    output logic [XLEN-1:0]          io_lookup_data,
    output logic [$clog2(DEPTH):0]   io_count
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0] result_q [DEPTH];
    logic [AW-1:0]   addr_q   [DEPTH];
    logic [IW-1:0]   rd_idx, wr_idx, off;
    logic [DEPTH-1:0] valid_mask;
    logic            empty, full, enq, deq, bypass;

    assign rd_idx   = rd_ptr_q[IW-1:0];
    assign wr_idx   = wr_ptr_q[IW-1:0];
    assign empty    = wr_ptr_q == rd_ptr_q;
    assign full     = (wr_idx == rd_idx) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
    assign io_count = wr_ptr_q - rd_ptr_q;

    assign io_in_ready = !full | io_out_ready;

`ifdef IBEX_WB_QUEUE_BYPASS_EN
    assign bypass = empty & io_in_valid & (io_in_rd_addr != '0) & io_out_ready & !io_flush;
`else
    assign bypass = 1'b0;
`endif

    // x0 writes and bypassed results complete the handshake without occupying a slot
    assign enq = io_in_valid & io_in_ready & !io_flush & (io_in_rd_addr != '0) & !bypass;
    assign deq = !empty & io_out_ready & !io_flush;

    assign io_out_valid   = !empty | bypass;
    assign io_out_result  = bypass ? io_in_result  : result_q[rd_idx];
    assign io_out_rd_addr = bypass ? io_in_rd_addr : addr_q[rd_idx];

    always_comb begin
        wr_ptr_d = io_flush ? '0 : wr_ptr_q + PW'(enq);
        rd_ptr_d = io_flush ? '0 : rd_ptr_q + PW'(deq);
    end

    always_comb begin
        valid_mask = '0;
        off        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off           = IW'(i) - rd_idx;
            valid_mask[i] = {1'b0, off} < io_count;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                result_q[i] <= '0;
                addr_q[i]   <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (enq) begin
                result_q[wr_idx] <= io_in_result;
                addr_q[wr_idx]   <= io_in_rd_addr;
            end
        end
    end

    ibex_wb_fwd_lookup #(
        .DEPTH(DEPTH),
        .XLEN (XLEN),
        .AW   (AW)
    ) u_lookup (
        .result_i     (result_q),
        .addr_i       (addr_q),
        .valid_i      (valid_mask),
        .head_i       (rd_idx),
        .lookup_addr_i(io_lookup_addr),
        .hit_o        (io_lookup_hit),
        .data_o       (io_lookup_data)
    );

endmodule

// File: tb/tb_ibex_alu_wb_queue.sv
// tb_ibex_alu_wb_queue: directed scenarios plus random traffic checked against
// a queue-based reference model of the writeback FIFO.
module tb_ibex_alu_wb_queue;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  a;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, flush, lk_hit;
    logic [31:0] in_result, out_result, lk_data;
    logic [4:0]  in_rd, out_rd, lk_addr;
    logic [2:0]  count;

    ent_t        q[$];
    int          total = 0;
    int          bad   = 0;

    always #5 clock = ~clock;

    ibex_alu_wb_queue dut (
        .clock         (clock),
        .reset         (reset),
        .io_in_valid   (in_valid),
        .io_in_ready   (in_ready),
        .io_in_result  (in_result),
        .io_in_rd_addr (in_rd),
        .io_out_valid  (out_valid),
        .io_out_ready  (out_ready),
        .io_out_result (out_result),
        .io_out_rd_addr(out_rd),
        .io_flush      (flush),
        .io_lookup_addr(lk_addr),
        .io_lookup_hit (lk_hit),
        .io_lookup_data(lk_data),
        .io_count      (count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // drive one cycle's inputs, check outputs against the model, then commit the model
    task automatic step(input logic v, input logic [4:0] rd, input logic [31:0] d,
                        input logic rdy, input logic fl, input logic [4:0] la);
        logic        e_rdy, e_ov, e_hit, byp, do_deq, do_enq;
        logic [31:0] e_res, e_ldata;
        logic [4:0]  e_addr;
        @(negedge clock);
        in_valid = v; in_rd = rd; in_result = d; out_ready = rdy; flush = fl; lk_addr = la;
        #1;
        e_rdy = (q.size() < 4) || rdy;
`ifdef IBEX_WB_QUEUE_BYPASS_EN
        byp = (q.size() == 0) && v && rd != 0 && rdy && !fl;
`else
        byp = 1'b0;
`endif
        e_ov   = (q.size() != 0) || byp;
        e_res  = byp ? d  : (q.size() != 0 ? q[0].d : 32'h0);
        e_addr = byp ? rd : (q.size() != 0 ? q[0].a : 5'h0);
        e_hit = 1'b0; e_ldata = 32'h0;
        if (la != 0)
            foreach (q[i])
                if (q[i].a == la) begin
                    e_hit = 1'b1; e_ldata = q[i].d;
                end
        check("in_ready", {31'h0, in_ready}, {31'h0, e_rdy});
        check("out_valid", {31'h0, out_valid}, {31'h0, e_ov});
        check("count", {29'h0, count}, q.size());
        check("lookup_hit", {31'h0, lk_hit}, {31'h0, e_hit});
        check("lookup_data", lk_data, e_ldata);
        if (e_ov) begin
            check("out_result", out_result, e_res);
            check("out_rd", {27'h0, out_rd}, {27'h0, e_addr});
        end
        do_deq = !fl && q.size() != 0 && rdy;
        do_enq = !fl && v && e_rdy && rd != 0 && !byp;
        if (fl) q.delete();
        if (do_deq) void'(q.pop_front());
        if (do_enq) q.push_back('{d: d, a: rd});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 0; in_rd = 0; in_result = 0; out_ready = 0; flush = 0; lk_addr = 0;
        #1;
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_count", {29'h0, count}, 32'h0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_hit", {31'h0, lk_hit}, 32'h0);
        #22 reset = 1'b0;

        // reset asserted asynchronously between edges with two entries held
        step(1, 5'd3, 32'h3333, 0, 0, 5'd3);
        step(1, 5'd4, 32'h4444, 0, 0, 5'd4);
        step(0, 5'd0, 32'h0, 0, 0, 5'd4);
        check("pre_rst_count", {29'h0, count}, 32'h2);
        #1 in_valid = 0; out_ready = 0; flush = 0;
        #1 reset = 1'b1;
        #1;
        check("async_out_valid", {31'h0, out_valid}, 32'h0);
        check("async_count", {29'h0, count}, 32'h0);
        check("async_out_result", out_result, 32'h0);
        check("async_hit", {31'h0, lk_hit}, 32'h0);
        q.delete();
        #1 reset = 1'b0;

        // fill to full, then drain in order
        step(1, 5'd1, 32'h11, 0, 0, 5'd0);
        step(1, 5'd2, 32'h22, 0, 0, 5'd0);
        step(1, 5'd3, 32'h33, 0, 0, 5'd0);
        step(1, 5'd4, 32'h44, 0, 0, 5'd0);
        step(1, 5'd9, 32'h99, 0, 0, 5'd2);
        check("full_count", {29'h0, count}, 32'h4);
        check("full_in_ready", {31'h0, in_ready}, 32'h0);
        // full with simultaneous enqueue/dequeue over three wraps
        for (int i = 0; i < 12; i++) step(1, 5'(5 + i), 32'h55 + i, 1, 0, 5'(5 + i));
        for (int i = 0; i < 5; i++) step(0, 5'd0, 32'h0, 1, 0, 5'd0);

        // x0 is accepted but never stored
        step(1, 5'd0, 32'hDEADBEEF, 0, 0, 5'd0);
        step(0, 5'd0, 32'h0, 0, 0, 5'd0);
        check("x0_count", {29'h0, count}, 32'h0);
        check("x0_out_valid", {31'h0, out_valid}, 32'h0);

        // youngest match wins
        step(1, 5'd7, 32'hA, 0, 0, 5'd0);
        step(1, 5'd7, 32'hB, 0, 0, 5'd7);
        step(1, 5'd1, 32'hC, 0, 0, 5'd7);
        check("fwd_hit", {31'h0, lk_hit}, 32'h1);
        check("fwd_data", lk_data, 32'hB);
        step(0, 5'd0, 32'h0, 0, 0, 5'd8);
        check("fwd_miss_data", lk_data, 32'h0);

        // flush beats a concurrent enqueue
        step(1, 5'd2, 32'hF00D, 1, 1, 5'd2);
        step(0, 5'd0, 32'h0, 0, 0, 5'd2);
        check("flush_count", {29'h0, count}, 32'h0);
        check("flush_out_valid", {31'h0, out_valid}, 32'h0);
        idle(2);

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0, 5'($urandom_range(0, 8)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ibex_alu_wb_queue.md
Name: ibex_alu_wb_queue

Overview:
- Writeback result queue directly downstream of the reduced-ALU bitwise stage.
- Captures each ALU result (io_bwlogic_result) with its destination register address and buffers it in a small in-order FIFO.
- Drains the FIFO to the register-file write port under a valid/ready handshake.
- Provides a forwarding lookup so the issue logic can read the youngest pending value for a register.

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.
- XLEN, 32, result data width.
- AW, 5, register address width.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- io_in_valid  input  1  ALU result valid.
- io_in_ready  output  1  queue can accept this cycle.
- io_in_result  input  XLEN  ALU result (from io_bwlogic_result).
- io_in_rd_addr  input  AW  destination register.
- io_out_valid  output  1  head entry valid.
- io_out_ready  input  1  register file accepts head.
- io_out_result  output  XLEN  head data.
- io_out_rd_addr  output  AW  head destination.
- io_flush  input  1  discard all entries.
- io_lookup_addr  input  AW  register to forward.
- io_lookup_hit  output  1  a pending entry matches.
- io_lookup_data  output  XLEN  youngest matching entry's data.
- io_count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-high (reset).
- Reset (asserted at any time, including mid-transfer):
  - Read/write pointers := 0; count := 0; all storage := 0.
  - io_out_valid = 0, io_out_result = 0, io_out_rd_addr = 0, io_lookup_hit = 0, io_count = 0.
- Storage and pointers:
  - Circular buffer of DEPTH entries {result, rd_addr}.
  - Pointers carry an extra wrap bit. Empty when pointers are equal; full when the index bits are equal and the wrap bits differ.
  - Pointers wrap from DEPTH-1 to 0 and toggle the wrap bit.
- Enqueue fires when io_in_valid & io_in_ready & !io_flush.
  - rd_addr == 0 (x0): the transfer is accepted but nothing is stored and count is unchanged.
- Dequeue fires when io_out_valid & io_out_ready.
- io_in_ready = !full | io_out_ready.
  - When full, a simultaneous dequeue frees a slot in the same cycle.
  - This is a combinational out_ready -> in_ready path, permitted by design.
- io_out_valid = !empty. io_out_result/io_out_rd_addr come from the head entry, registered storage only.
- Latency: an enqueued entry is visible at the output on the next cycle.
- Simultaneous enqueue + dequeue: count unchanged; both pointers advance.
- Flush has priority over enqueue and dequeue.
  - Next cycle: pointers equal, count 0, io_out_valid 0.
  - In the flush cycle io_out_valid still reflects the pre-flush state, but no dequeue takes effect.
- io_count = write pointer - read pointer (modulo 2*DEPTH); range 0..DEPTH.
- Lookup (combinational):
  - Scans valid entries from oldest to youngest; the last match wins.
  - io_lookup_addr == 0: io_lookup_hit = 0 and io_lookup_data = 0.
  - No match: hit = 0, data = 0.
  - Entries being dequeued this cycle still count as matches.
  - The incoming io_in_* entry does not count as a match.
- Only the register-file consumer drives io_out_ready; ordering is strictly FIFO.

Optional Feature:
- Macro: IBEX_WB_QUEUE_BYPASS_EN.
- When defined, and the queue is empty, io_in_valid is high, rd_addr != 0 and io_out_ready is high:
  - The input passes combinationally to io_out_* with zero latency and is not stored.
  - io_out_valid = 1 that cycle.
  - io_count is unaffected.
- When undefined: strict 1-cycle minimum latency; io_out_* depend only on registered state.

Decomposition:
- Package ibex_alu_pkg holds:
  - XLEN_C = 32 and AW_C = 5.
  - The typedef wb_entry_t {logic [XLEN-1:0] result; logic [AW-1:0] rd_addr;}.
  - The ALU operator encoding constants (ALU_AND = 7'h4, etc.), shared with the bitwise stage.
- One sub-module is natural: ibex_wb_fwd_lookup, a combinational youngest-match search over the entry array plus valid mask.

Test Plan:
- Reset mid-stream: fill 2 entries, then assert reset asynchronously between edges -> io_out_valid = 0 and io_count = 0 immediately; io_out_result = 0.
- Fill to full: enqueue rd 1..4 with data 0x11,0x22,0x33,0x44 while io_out_ready = 0 -> io_count = 4 and io_in_ready = 0; drain -> outputs appear in order 0x11..0x44, then io_out_valid = 0.
- Full with simultaneous enqueue/dequeue: at count 4, io_in_valid = 1 and io_out_ready = 1 with rd 5 / data 0x55 -> io_in_ready = 1 and count stays 4; pointer wrap verified over 3 full passes.
- x0 drop: enqueue rd 0 with data 0xDEADBEEF -> handshake completes, io_count stays 0, io_out_valid stays 0.
- Forwarding: enqueue (rd 7, 0xA) then (rd 7, 0xB); io_lookup_addr = 7 -> hit = 1, data = 0xB; io_lookup_addr = 8 -> hit = 0, data = 0.
- Flush priority: at count 3, pulse io_flush together with io_in_valid (rd 2) -> next cycle io_count = 0 and io_out_valid = 0; the flushed input is never output.
